// File: rtl/memory_sp.sv
// Single-port word memory with byte-lane writes and a power-up initialisation sweep.
// Latency: one cycle from request accept to response; the init sweep takes DEPTH cycles after reset.
// Backpressure: a held response (rsp_valid=1, rsp_ready=0) drops req_ready; requests wait upstream.
module memory_sp #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 7,
  parameter int DEPTH     = 128,
  parameter int INIT_MODE = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_busy
);

  localparam int LANES = DATA_W / 8;
  // Index width just large enough to address DEPTH words (never wider than ADDR_W).
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Response payload travels as one packed word so it is held as a unit.
  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  sweep_cnt;
  logic              sweep_last;

  logic              accept;
  logic              addr_ok;
  logic [IDX_W-1:0]  req_idx;
  logic [DATA_W-1:0] cur_word;
  logic [DATA_W-1:0] merged_word;
  logic [DATA_W-1:0] init_val;
  logic [DATA_W+IDX_W-1:0] init_ext;
  rsp_t              rsp_q;
  rsp_t              rsp_nxt;

  // Out-of-range addresses never touch the array; the index is only meaningful when addr_ok.
  assign addr_ok    = ({1'b0, req_addr} < DEPTH_L);
  assign req_idx    = req_addr[IDX_W-1:0];
  assign sweep_last = (sweep_cnt == LAST_IDX);
  assign accept     = req_valid && req_ready;

  // Init value is the word index, zero-extended or truncated to the data width.
  assign init_ext = {{DATA_W{1'b0}}, sweep_cnt};
  assign init_val = (INIT_MODE == 0) ? '0 : init_ext[DATA_W-1:0];

  // Current word at the request address, zero for addresses outside the array.
  always_comb begin
    cur_word = '0;
    if (addr_ok) begin
      cur_word = mem[req_idx];
    end
  end

  // Byte-lane merge of write data over the current word.
  always_comb begin
    merged_word = cur_word;
    for (int k = 0; k < LANES; k++) begin
      if (req_be[k]) begin
        merged_word[8*k +: 8] = req_wdata[8*k +: 8];
      end
    end
  end

  // Next response: a write reports the merged word, a read the pre-edge word, a bad address zero.
  always_comb begin
    rsp_nxt       = '0;
    rsp_nxt.err   = !addr_ok;
    if (addr_ok) begin
      rsp_nxt.rdata = req_we ? merged_word : cur_word;
    end
  end

  // FSM next state and status outputs; requests are only taken in RUN with the response slot free.
  always_comb begin
    state_nxt = state;
    init_busy = 1'b0;
    req_ready = 1'b0;
    case (state)
      ST_INIT: begin
        init_busy = 1'b1;
        if (sweep_last) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        req_ready = !rsp_valid || rsp_ready;
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Sweep counter: advances one word per cycle in INIT, parked at zero once running.
  always_ff @(posedge clock) begin
    if (reset) begin
      sweep_cnt <= '0;
    end else if (state == ST_INIT) begin
      sweep_cnt <= sweep_last ? '0 : sweep_cnt + 1'b1;
    end
  end

  // Array writes: sweep words during INIT, accepted in-range writes during RUN; untouched while in reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == ST_INIT) begin
        mem[sweep_cnt] <= init_val;
      end else if (accept && req_we && addr_ok) begin
        mem[req_idx] <= merged_word;
      end
    end
  end

  // Response register: loads on accept, clears when consumed, holds while stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_q     <= rsp_nxt;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;

endmodule

// File: doc/memory_sp.md
MEMORY_SP -- requirements
Module: memory_sp

Interface
REQ-001 Parameter DATA_W, default 8: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 7: address width in bits.
REQ-003 Parameter DEPTH, default 128: number of words; SHALL satisfy 1 <= DEPTH <= 2**ADDR_W.
REQ-004 Parameter INIT_MODE, default 1: 0 = clear every word to zero; 1 = word[i] = i, zero-extended or truncated to DATA_W.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  block accepts a request this cycle.
REQ-009 req_we  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDR_W  word address.
REQ-011 req_wdata  input  DATA_W  write data.
REQ-012 req_be  input  DATA_W/8  byte-lane write enables; bit k covers bits [8k+7:8k].
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  consumer takes the response this cycle.
REQ-015 rsp_rdata  output  DATA_W  read data, or the merged word after a write.
REQ-016 rsp_err  output  1  request address was >= DEPTH.
REQ-017 init_busy  output  1  initialisation sweep in progress.

Function
REQ-018 The block SHALL use a two-state FSM: INIT and RUN.
REQ-019 In INIT, a counter starting at 0 SHALL write the INIT_MODE value to one word per cycle; after writing word DEPTH-1, the FSM SHALL move to RUN on the next edge. The sweep SHALL take exactly DEPTH cycles.
REQ-020 init_busy SHALL be 1 in INIT and 0 in RUN.
REQ-021 req_ready SHALL equal (state==RUN) AND (NOT rsp_valid OR rsp_ready), combinationally.
REQ-022 A request SHALL be accepted on a rising edge where req_valid AND req_ready are both 1.
REQ-023 An accepted write with req_addr < DEPTH SHALL update only the lanes whose req_be bit is 1, at the accept edge.
REQ-024 Read latency SHALL be 1 cycle: rsp_valid SHALL rise at the accept edge, and rsp_rdata SHALL hold the word as it stood before that edge.
REQ-025 An accepted write SHALL also produce a response on the same timing, with rsp_rdata equal to the merged post-write word.
REQ-026 For req_addr >= DEPTH: the array SHALL be unchanged, rsp_rdata SHALL be 0, and rsp_err SHALL be 1. Otherwise rsp_err SHALL be 0.
REQ-027 While rsp_valid=1 and rsp_ready=0, rsp_valid, rsp_rdata and rsp_err SHALL hold stable.
REQ-028 rsp_valid SHALL fall after an edge with rsp_ready=1 and no new accept. With rsp_ready held high, sustained throughput SHALL be one request per cycle.
REQ-029 Back-to-back write then read of the same address SHALL return the newly written data (no stale read).
REQ-030 A write with req_be all zero SHALL be accepted and acknowledged, with the array unchanged.
REQ-031 Requests presented while in INIT SHALL NOT be accepted; req_valid SHALL be ignored there.

Reset
REQ-032 While reset=1 at an edge: state SHALL go to INIT, the sweep counter SHALL go to 0, rsp_valid, rsp_err and rsp_rdata SHALL go to 0, and init_busy SHALL be 1.
REQ-033 Array contents SHALL NOT be altered during reset itself; the sweep SHALL start on the first edge with reset=0.
REQ-034 Reset asserted mid-sweep or mid-transaction SHALL discard any pending response and restart the full sweep.

Verification (DATA_W=16, ADDR_W=4, DEPTH=12, INIT_MODE=1)
REQ-035 Release reset, then read addr 0..11 -> init_busy high for exactly 12 cycles; reads return 0x0000..0x000B; rsp_err=0.
REQ-036 Write addr 1 data 0x3A5C be=2'b01, then read addr 1 -> write rsp_rdata=0x005C; read returns 0x005C.
REQ-037 Read addr 13, then write addr 15 data 0xFFFF be=2'b11 -> each returns rsp_err=1 and rsp_rdata=0x0000; rereading addr 0..11 shows no change.
REQ-038 Hold rsp_ready=0 for 3 cycles after a read of addr 5 -> req_ready=0, rsp_rdata stays 0x0005, and no second accept occurs; rsp_ready=1 -> rsp_valid falls.
REQ-039 With rsp_ready=1, issue back-to-back write addr 2=0xBEEF then read addr 2 on consecutive cycles -> two responses on consecutive cycles, the second being 0xBEEF.
REQ-040 Assert reset for 1 cycle at sweep count 6, and separately during a held response -> rsp_valid=0 and the sweep restarts at 0 and runs 12 cycles; addr 2 then reads 0x0002.
